// File: rtl/aes_ctrl_pkg.sv
// Shared types, encodings and helpers for the AES round sequencer.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MID,
        FINAL,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        KS_128  = 2'b00,
        KS_192  = 2'b01,
        KS_256  = 2'b10,
        KS_RSVD = 2'b11
    } key_size_t;

    // addRoundKey_stateMux encodings
    localparam logic [1:0] SM_INPUT = 2'b00;
    localparam logic [1:0] SM_FULL  = 2'b10;
    localparam logic [1:0] SM_FINAL = 2'b01;

    // Number of rounds for a key size; the reserved code falls back to AES-128
    function automatic logic [3:0] nr_for(key_size_t ks);
        logic [3:0] nr;
        case (ks)
            KS_192:  nr = 4'd12;
            KS_256:  nr = 4'd14;
            default: nr = 4'd10;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_timer.sv
// Per-round cycle timer: counts 0..CYCLES_PER_ROUND-1 while run is high and
// flags the last cycle of each round with tick. With one cycle per round the
// counter never leaves 0 and tick simply follows run.
module round_timer #(
    parameter int CYCLES_PER_ROUND = 2,
    localparam int CW = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic [CW-1:0] cyc,
    output logic          tick
);

    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_ROUND - 1);

    if (CYCLES_PER_ROUND < 1) begin : g_cpr_check
        $error("round_timer: CYCLES_PER_ROUND must be at least 1");
    end

    assign tick = run && (cyc == LAST);

    // Advance within a round, wrap on the final cycle, park at 0 when idle
    always_ff @(posedge clk) begin
        if (reset || !run || tick) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + CW'(1);
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Multi-cycle AES round controller for the shared AddRoundKey/KeyExpansion
// datapath: AES-128/192/256, encrypt or decrypt, busy/done handshake.
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int CYCLES_PER_ROUND = 2,
    parameter int MAX_ROUNDS       = 14
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load,
    input  logic [1:0]                        key_size,
    input  logic                              decrypt,
    output logic                              reg_en,
    output logic [$clog2(MAX_ROUNDS+1)-1:0]   round,
    output logic                              addRoundKey_keyMux,
    output logic                              genRoundKey_mux,
    output logic [1:0]                        addRoundKey_stateMux,
    output logic                              last_round,
    output logic                              busy,
    output logic                              done
);

    localparam int RW = $clog2(MAX_ROUNDS + 1);
    localparam int CW = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(CYCLES_PER_ROUND - 1);

    seq_state_t    state_q;
    seq_state_t    state_d;
    logic [RW-1:0] rnd_q;
    logic [RW-1:0] nr_q;
    logic          dec_q;
    logic          run;
    logic          tick;
    logic          accept;
    logic [CW-1:0] cyc;

    assign run    = (state_q == INIT) || (state_q == MID) || (state_q == FINAL);
    assign accept = (state_q == IDLE) && load;

    round_timer #(
        .CYCLES_PER_ROUND(CYCLES_PER_ROUND)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .cyc  (cyc),
        .tick (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run configuration capture, executed-round counter and done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rnd_q  <= '0;
            nr_q   <= '0;
            dec_q  <= 1'b0;
            done   <= 1'b0;
        end else if (accept) begin
            rnd_q  <= '0;
            nr_q   <= RW'(nr_for(key_size_t'(key_size)));
            dec_q  <= decrypt;
            done   <= 1'b0;
        end else if (state_q == DONE) begin
            rnd_q  <= '0;
            done   <= 1'b1;
        end else if (tick && (state_q != FINAL)) begin
            rnd_q  <= rnd_q + RW'(1);
        end
    end

    // Next-state logic: each busy state advances only on the round tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (load) state_d = INIT;
            INIT:  if (tick) state_d = (nr_q > RW'(1)) ? MID : FINAL;
            MID:   if (tick && (rnd_q == nr_q - RW'(1))) state_d = FINAL;
            FINAL: if (tick) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls decoded from state, round count and direction
    always_comb begin
        reg_en               = 1'b0;
        round                = '0;
        addRoundKey_keyMux   = 1'b0;
        genRoundKey_mux      = 1'b0;
        addRoundKey_stateMux = SM_INPUT;
        last_round           = 1'b0;
        busy                 = 1'b0;
        if (run) begin
            busy   = 1'b1;
            reg_en = (cyc == LAST_CYC);
            round  = dec_q ? (nr_q - rnd_q) : rnd_q;
        end
        case (state_q)
            MID: begin
                genRoundKey_mux      = (rnd_q != RW'(1));
                addRoundKey_stateMux = SM_FULL;
                addRoundKey_keyMux   = 1'b1;
            end
            FINAL: begin
                genRoundKey_mux      = 1'b1;
                addRoundKey_stateMux = SM_FINAL;
                addRoundKey_keyMux   = 1'b1;
                last_round           = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: one instance with two cycles
// per round and one with a single cycle per round, compared cycle by cycle
// against a round-schedule model derived from elapsed time since load.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load2;
    logic       load1;
    logic [1:0] key_size;
    logic       decrypt;

    logic       reg_en2, kk2, gk2, last2, busy2, done2;
    logic [3:0] round2;
    logic [1:0] sm2;
    logic       reg_en1, kk1, gk1, last1, busy1, done1;
    logic [3:0] round1;
    logic [1:0] sm1;

    int checks = 0;
    int errors = 0;
    bit doneExp [2];

    always #5 clk = ~clk;

    aes_round_sequencer #(.CYCLES_PER_ROUND(2), .MAX_ROUNDS(14)) dut2 (
        .clk(clk), .reset(reset), .load(load2), .key_size(key_size), .decrypt(decrypt),
        .reg_en(reg_en2), .round(round2), .addRoundKey_keyMux(kk2), .genRoundKey_mux(gk2),
        .addRoundKey_stateMux(sm2), .last_round(last2), .busy(busy2), .done(done2)
    );

    aes_round_sequencer #(.CYCLES_PER_ROUND(1), .MAX_ROUNDS(14)) dut1 (
        .clk(clk), .reset(reset), .load(load1), .key_size(key_size), .decrypt(decrypt),
        .reg_en(reg_en1), .round(round1), .addRoundKey_keyMux(kk1), .genRoundKey_mux(gk1),
        .addRoundKey_stateMux(sm1), .last_round(last1), .busy(busy1), .done(done1)
    );

    // Output snapshot: {busy, reg_en, round[3:0], gk, sm[1:0], kk, last, done}
    function automatic logic [11:0] observe(bit sel);
        if (sel)
            return {busy1, reg_en1, round1, gk1, sm1, kk1, last1, done1};
        return {busy2, reg_en2, round2, gk2, sm2, kk2, last2, done2};
    endfunction

    function automatic int nrModel(logic [1:0] ks);
        if (ks == 2'b01) return 12;
        if (ks == 2'b10) return 14;
        return 10;
    endfunction

    // Expected outputs t cycles after the accepting edge: rounds 0..nr each
    // occupy cpr cycles, then one quiet cycle, then idle with done raised
    function automatic logic [11:0] expected(int nr, int cpr, bit dec, int t);
        int         total;
        int         r;
        logic [3:0] rd;
        logic [1:0] sm;
        logic       regEn;
        total = (nr + 1) * cpr;
        if (t > total) return 12'h001;
        if (t == total) return 12'h000;
        r     = t / cpr;
        rd    = dec ? 4'(nr - r) : 4'(r);
        regEn = ((t % cpr) == cpr - 1);
        if (r == 0)       sm = 2'b00;
        else if (r == nr) sm = 2'b01;
        else              sm = 2'b10;
        return {1'b1, regEn, rd, (r >= 2), sm, (r != 0), (r == nr), 1'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setLoad(input bit sel, input logic v);
        if (sel) load1 = v;
        else     load2 = v;
    endtask

    // One complete run on the selected instance; noisy scrambles load and
    // the configuration inputs while busy, holdLoad leaves load asserted
    task automatic applyStimulus(input bit sel, input logic [1:0] ks, input bit dec,
                                 input bit noisy, input bit holdLoad);
        int          nr;
        int          cpr;
        int          total;
        int          pulses;
        logic [11:0] o;
        nr     = nrModel(ks);
        cpr    = sel ? 1 : 2;
        total  = (nr + 1) * cpr;
        pulses = 0;
        key_size = ks;
        decrypt  = dec;
        setLoad(sel, 1'b1);
        for (int t = 0; t <= total + 1; t++) begin
            @(negedge clk);
            o = observe(sel);
            if (o[10]) pulses++;
            checkOutput($sformatf("run sel%0d nr%0d dec%0d t%0d", sel, nr, dec, t), o,
                        expected(nr, cpr, dec, t));
            if (t <= total && noisy) begin
                setLoad(sel, 1'($urandom_range(0, 1)));
                key_size = 2'($urandom);
                decrypt  = 1'($urandom);
            end else begin
                setLoad(sel, holdLoad);
            end
        end
        checkOutput($sformatf("regEnCount sel%0d nr%0d", sel, nr), 12'(pulses), 12'(nr + 1));
        doneExp[sel] = 1'b1;
    endtask

    task automatic idleCheck(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle sel%0d", sel), observe(sel), {11'b0, doneExp[sel]});
        end
    endtask

    // Start an AES-128 run on the two-cycle instance and reset it at round 7
    task automatic abortRun();
        key_size = 2'b00;
        decrypt  = 1'($urandom);
        setLoad(0, 1'b1);
        for (int t = 0; t <= 14; t++) begin
            @(negedge clk);
            checkOutput($sformatf("abortPre t%0d", t), observe(0), expected(10, 2, decrypt, t));
            setLoad(0, 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        doneExp[0] = 1'b0;
        doneExp[1] = 1'b0;
        checkOutput("abortReset", observe(0), 12'h000);
        checkOutput("abortResetOther", observe(1), 12'h000);
        reset = 1'b0;
        idleCheck(0, 2);
    endtask

    initial begin
        reset    = 1'b1;
        load2    = 1'b1;
        load1    = 1'b1;
        key_size = 2'b00;
        decrypt  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetState cpr2", observe(0), 12'h000);
        checkOutput("resetState cpr1", observe(1), 12'h000);
        reset = 1'b0;
        load2 = 1'b0;
        load1 = 1'b0;
        idleCheck(0, 1);
        idleCheck(1, 1);

        $display("[TB] AES-128 encrypt, 2 cycles per round");
        applyStimulus(0, 2'b00, 1'b0, 1'b0, 1'b0);
        idleCheck(0, 2);

        $display("[TB] AES-256 decrypt, 1 cycle per round");
        applyStimulus(1, 2'b10, 1'b1, 1'b0, 1'b0);
        idleCheck(1, 1);

        $display("[TB] reserved key size, clean and with mid-run input changes");
        applyStimulus(0, 2'b11, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 2'b11, 1'b0, 1'b1, 1'b0);

        $display("[TB] AES-192 with load re-asserted while busy");
        applyStimulus(0, 2'b01, 1'b0, 1'b1, 1'b0);
        idleCheck(0, 1);

        $display("[TB] reset mid-run, then clean restart");
        abortRun();
        applyStimulus(0, 2'b00, 1'b1, 1'b0, 1'b0);

        $display("[TB] load held across back-to-back runs");
        applyStimulus(1, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 2'b01, 1'b1, 1'b0, 1'b0);
        idleCheck(1, 1);

        $display("[TB] randomized runs");
        for (int i = 0; i < 16; i++) begin
            bit          sel;
            logic [1:0]  ks;
            sel = 1'($urandom);
            ks  = 2'($urandom);
            applyStimulus(sel, ks, 1'($urandom), 1'($urandom), 1'b0);
            idleCheck(sel, $urandom_range(0, 3));
        end

        $display("[TB] reset while idle clears done");
        reset = 1'b1;
        @(negedge clk);
        doneExp[0] = 1'b0;
        doneExp[1] = 1'b0;
        checkOutput("idleReset cpr2", observe(0), 12'h000);
        checkOutput("idleReset cpr1", observe(1), 12'h000);
        reset = 1'b0;
        idleCheck(0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
